div: RTL and testbench

// - Multi-cycle 32-bit signed/unsigned integer divider for DIV/DIVU, driven by the EX-stage ALU.
// - ALU holds start and operands, stalls the pipeline until ready_o, then forwards result_o to HI/LO.
// - Radix-2 restoring algorithm: one quotient bit per clock, with a fast path for divide-by-zero.

---
 rtl/div_pkg.sv | 15 +
 rtl/div.sv | 105 ++++++++++
 tb/tb_div.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: state encodings and handshake constants shared by the divider and the ALU
package div_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W = 6;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
endpackage

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per clock
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  div_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2*DATA_W:0] dividend, dividend_n;
  logic [DATA_W-1:0] divisor, divisor_n, mag1, mag2, q, r;
  logic [DATA_W:0] diff;
  logic sgn, sgn_n, neg1, neg1_n, neg2, neg2_n, ready, ready_n;
  logic [2*DATA_W-1:0] result, result_n;
  always_comb begin
    mag1 = signed_div_i && opdata1_i[DATA_W-1] ? -opdata1_i : opdata1_i;
    mag2 = signed_div_i && opdata2_i[DATA_W-1] ? -opdata2_i : opdata2_i;
    diff = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    q = sgn && (neg1 ^ neg2) ? -dividend[DATA_W-1:0] : dividend[DATA_W-1:0];
    r = sgn && neg1 ? -dividend[2*DATA_W:DATA_W+1] : dividend[2*DATA_W:DATA_W+1];
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dividend_n = dividend;
    divisor_n = divisor;
    sgn_n = sgn;
    neg1_n = neg1;
    neg2_n = neg2;
    result_n = result;
    ready_n = ready;
    case (state)
      DIV_FREE:
        if (start_i == DIV_START && !annul_i) begin
          state_n = opdata2_i == '0 ? DIV_BYZERO : DIV_ON;
          cnt_n = '0;
          sgn_n = signed_div_i;
          neg1_n = opdata1_i[DATA_W-1];
          neg2_n = opdata2_i[DATA_W-1];
          divisor_n = mag2;
          dividend_n = {{DATA_W{1'b0}}, mag1, 1'b0};
        end
      DIV_BYZERO: begin
        state_n = DIV_END;
        result_n = '0;
        ready_n = DIV_RESULT_READY;
      end
      DIV_ON:
        if (annul_i) begin
          state_n = DIV_FREE;
          cnt_n = '0;
          result_n = '0;
          ready_n = DIV_RESULT_NOT_READY;
        end else if (cnt != CNT_W'(DATA_W)) begin
          cnt_n = cnt + 1'b1;
          dividend_n = diff[DATA_W] ? dividend << 1 : {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
        end else begin
          state_n = DIV_END;
          result_n = {r, q};
          ready_n = DIV_RESULT_READY;
        end
      DIV_END:
        if (start_i == DIV_STOP) begin
          state_n = DIV_FREE;
          result_n = '0;
          ready_n = DIV_RESULT_NOT_READY;
        end
      default: state_n = DIV_FREE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= DIV_FREE;
      cnt <= '0;
      dividend <= '0;
      divisor <= '0;
      sgn <= 1'b0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      result <= '0;
      ready <= DIV_RESULT_NOT_READY;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dividend <= dividend_n;
      divisor <= divisor_n;
      sgn <= sgn_n;
      neg1 <= neg1_n;
      neg2 <= neg2_n;
      result <= result_n;
      ready <= ready_n;
    end
  assign result_o = result;
  assign ready_o = ready;
endmodule

// File: tb/tb_div.sv
// tb_div: randomized scoreboard bench for div against a plain-arithmetic division model
module tb_div;
  logic clk = 0, rst = 0, signed_div = 0, start = 0, annul = 0;
  logic [31:0] op1 = 0, op2 = 0;
  logic [63:0] result;
  logic ready, ready_d = 0;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 0) return 64'd0;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (ready && !ready_d) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 64'd1, 64'd0);
      else chk("result", result, exp_q.pop_front());
    end
    ready_d = ready;
  end

  task automatic wait_ready(input bit scramble, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ready || n >= 40) break;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = 1'($urandom);
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b, input int extra, input bit scramble);
    int n;
    logic [63:0] held;
    exp_q.push_back(model(s, a, b));
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1; annul = 0;
    @(posedge clk);
    wait_ready(scramble, n);
    chk("latency", 64'(n), b == 0 ? 64'd1 : 64'd33);
    held = result;
    repeat (extra) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold", {63'd0, ready}, 64'd1);
      chk("hold_result", result, held);
    end
    start = 0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_ready", {63'd0, ready}, 64'd0);
    chk("drop_result", result, 64'd0);
  endtask

  task automatic quiet(input string name);
    bit rose = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) rose = 1;
    end
    chk(name, {63'd0, rose}, 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1;
    op(0, 100, 7, 5, 0);
    op(1, -32'sd7, 2, 0, 0);
    op(1, 7, -32'sd2, 0, 0);
    op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    op(1, 5, 0, 2, 0);
    op(0, 5, 0, 0, 0);
    op(1, 0, 12345, 0, 0);
    op(0, 3, 1000, 0, 0);
    op(1, -32'sd3, 1000, 0, 0);
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    op(0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1);
    op(1, 32'h8765_4321, 32'h0000_00F3, 0, 1);
    // abort mid-flight: nothing is queued, so any ready rise is flagged
    @(negedge clk);
    signed_div = 0; op1 = 1234; op2 = 5; start = 1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1;
    @(posedge clk);
    @(negedge clk);
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_result", result, 64'd0);
    annul = 0; start = 0;
    quiet("annul_no_ready");
    op(0, 9, 3, 0, 0);
    @(negedge clk);
    signed_div = 0; op1 = 32'h0000_FFFF; op2 = 3; start = 1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 0; start = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    rst = 1;
    quiet("rst_no_ready");
    // reset while holding a finished result
    exp_q.push_back(model(0, 50, 7));
    @(negedge clk);
    signed_div = 0; op1 = 50; op2 = 7; start = 1;
    @(posedge clk);
    wait_ready(0, n);
    chk("end_latency", 64'(n), 64'd33);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_end_ready", {63'd0, ready}, 64'd0);
    chk("rst_end_result", result, 64'd0);
    rst = 1; start = 0;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = i % 7 == 0 ? 32'h8000_0000 : $urandom;
      b = $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom >> $urandom_range(0, 31);
      if (i % 9 == 0) b = 32'hFFFF_FFFF;
      op(1'($urandom), a, b, i % 4, i % 3 == 0);
    end
    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
